// File: rtl/snap_capture_ctrl.sv
// Write-side controller for the ADC calibration snapshot BRAM: arms from software,
// waits for a trigger, then streams exactly 2^ADDR_W qualified samples into port A.
module snap_capture_ctrl #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   input  logic              trig,
   input  logic [31:0]       ctrl,
   output logic              bram_we,
   output logic              bram_en_a,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [DATA_W-1:0] bram_wr_data,
   output logic [31:0]       status
);

   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_CAPTURE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t            state;
   logic [ADDR_W:0]   count;
   logic              ctrl0_d;
   logic              arm_edge;
   logic              v;
   logic              t;
   logic              accept;
   logic              last_word;
   logic [ADDR_W:0]   count_next;
   logic [31:0]       status_next;

   assign arm_edge   = ctrl[0] & ~ctrl0_d;
   assign v          = ctrl[2] | din_valid;
   assign t          = ctrl[1] | trig;
   assign count_next = count + {{ADDR_W{1'b0}}, 1'b1};
   assign last_word  = (count_next == DEPTH);

   // A re-arm always wins; the trigger cycle itself may carry the first word.
   always_comb begin
      accept = 1'b0;
      if (arm_edge) begin
         accept = 1'b0;
      end else begin
         case (state)
            S_ARMED:   accept = t & v;
            S_CAPTURE: accept = v;
            default:   accept = 1'b0;
         endcase
      end
   end

   always_comb begin
      status_next           = 32'd0;
      status_next[31]       = (state == S_DONE);
      status_next[30]       = (state == S_ARMED) || (state == S_CAPTURE);
      status_next[ADDR_W:0] = count;
   end

   // ctrl0_d follows ctrl[0] even in reset so a level held through reset is not an edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         count        <= '0;
         ctrl0_d      <= ctrl[0];
         bram_we      <= 1'b0;
         bram_en_a    <= 1'b0;
         bram_addr    <= '0;
         bram_wr_data <= '0;
         status       <= 32'd0;
      end else begin
         ctrl0_d   <= ctrl[0];
         status    <= status_next;
         bram_we   <= accept;
         bram_en_a <= accept;
         if (accept) begin
            bram_addr    <= count[ADDR_W-1:0];
            bram_wr_data <= din;
            count        <= count_next;
         end
         if (arm_edge) begin
            state <= S_ARMED;
            count <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  count <= '0;
               end
               S_ARMED: begin
                  if (t) begin
                     state <= (accept && last_word) ? S_DONE : S_CAPTURE;
                  end
               end
               S_CAPTURE: begin
                  if (accept && last_word) begin
                     state <= S_DONE;
                  end
               end
               S_DONE: begin
                  state <= S_DONE;
               end
               default: begin
                  state <= S_IDLE;
                  count <= '0;
               end
            endcase
         end
      end
   end

endmodule
